// File: rtl/uart_tx_fifo_serializer.sv
// Byte-wide UART transmitter (8N1) fed by a circular write FIFO.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_fifo_serializer #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16,
  parameter int ADDR_W       = 4
) (
  input  logic              clk_50M,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              busy,
  output logic              tx
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [ADDR_W:0]  DEPTH_LVL = (ADDR_W+1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t state, state_next;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   level_next;
  logic              push, pop;

  logic [7:0]        shift_reg;
  logic [2:0]        bit_cnt;
  logic [CNT_W-1:0]  baud_cnt;
  logic              bit_done;
  logic              tx_next;
`ifdef UART_TX_PARITY_EN
  logic              parity_q;
`endif

  // A full FIFO rejects the write even when a pop frees a slot this cycle.
  assign push     = wr_en && !full;
  assign bit_done = (baud_cnt == BAUD_LAST);
  assign busy     = (state != IDLE);

  always_comb begin
    level_next = level;
    case ({push, pop})
      2'b10:   level_next = level + 1'b1;
      2'b01:   level_next = level - 1'b1;
      default: level_next = level;
    endcase
  end

  // NOTE: storage has no reset; clearing the pointers is enough to discard queued bytes.
  always_ff @(posedge clk_50M) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // NOTE: every sequential block uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && full) overflow <= 1'b1;
      level <= level_next;
      full  <= (level_next == DEPTH_LVL);
      empty <= (level_next == '0);
    end
  end

  always_ff @(posedge clk_50M) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
  always_comb begin
    state_next = state;
    tx_next    = 1'b1;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: begin
        tx_next = 1'b0;
        if (bit_done) state_next = DATA;
      end
      DATA: begin
        tx_next = shift_reg[0];
        if (bit_done && bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_next = parity_q;
        if (bit_done) state_next = STOP;
      end
`endif
      STOP: begin
        tx_next = 1'b1;
        if (bit_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // tx is registered from the current state, so the line lags the FSM by one cycle.
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      tx        <= 1'b1;
      shift_reg <= '0;
      bit_cnt   <= '0;
      baud_cnt  <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      tx <= tx_next;
      if (pop) begin
        shift_reg <= mem[rd_ptr];
        bit_cnt   <= '0;
        baud_cnt  <= '0;
`ifdef UART_TX_PARITY_EN
        parity_q  <= ^mem[rd_ptr];
`endif
      end else if (state == IDLE) begin
        baud_cnt <= '0;
      end else if (bit_done) begin
        baud_cnt <= '0;
        if (state == DATA) begin
          shift_reg <= {1'b0, shift_reg[7:1]};
          bit_cnt   <= bit_cnt + 1'b1;
        end
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

endmodule
